// File: rtl/siso_pkg.sv
// Shared constants and helpers for the SISO decoder front end: default LLR
// width, default block length, step counter sizing and saturation limits.
package siso_pkg;

  localparam int LLR_W_DEFAULT   = 16;
  localparam int BLK_LEN_DEFAULT = 64;

  localparam logic signed [LLR_W_DEFAULT-1:0] LLR_SAT_MAX = 16'sh7fff;
  localparam logic signed [LLR_W_DEFAULT-1:0] LLR_SAT_MIN = 16'sh8000;

  // A block of two steps still needs one counter bit.
  function automatic int cnt_width(input int blk_len);
    return (blk_len > 2) ? $clog2(blk_len) : 1;
  endfunction

endpackage

// File: rtl/branch_metric_calc_if.sv
// Valid/ready stream bundle between the LLR source, the branch metric stage
// and the max-selection stage; slave is the branch metric calculator's view.
interface branch_metric_calc_if
  import siso_pkg::*;
#(
  parameter int DWIDTH = LLR_W_DEFAULT,
  parameter int CNT_W  = cnt_width(BLK_LEN_DEFAULT)
);

  logic              s_valid;
  logic              s_ready;
  logic [DWIDTH-1:0] s_sys;
  logic [DWIDTH-1:0] s_par;
  logic [DWIDTH-1:0] s_apr;
  logic              s_last;

  logic              m_valid;
  logic              m_ready;
  logic [DWIDTH-1:0] m_gamma_p;
  logic [DWIDTH-1:0] m_gamma_n;
  logic              m_last;
  logic [CNT_W-1:0]  m_step;
  logic              o_frame_err;

  modport slave (
    input  s_valid, s_sys, s_par, s_apr, s_last, m_ready,
    output s_ready, m_valid, m_gamma_p, m_gamma_n, m_last, m_step, o_frame_err
  );

  modport master (
    output s_valid, s_sys, s_par, s_apr, s_last, m_ready,
    input  s_ready, m_valid, m_gamma_p, m_gamma_n, m_last, m_step, o_frame_err
  );

endinterface

// File: rtl/llr_narrow.sv
// Narrows a DWIDTH+2 metric to DWIDTH bits: saturating when
// BRANCH_METRIC_SAT_EN is defined, otherwise keeping the low bits (wrap).
module llr_narrow #(
  parameter int DWIDTH = 16
) (
  input  logic [DWIDTH+1:0] din,
  output logic [DWIDTH-1:0] dout
);

`ifdef BRANCH_METRIC_SAT_EN
  logic overflow;

  // The value fits only when the top three bits are all equal.
  assign overflow = !(&din[DWIDTH+1:DWIDTH-1]) && (|din[DWIDTH+1:DWIDTH-1]);
  assign dout     = overflow ? {din[DWIDTH+1], {(DWIDTH-1){!din[DWIDTH+1]}}}
                             : din[DWIDTH-1:0];
`else
  logic unused_hi;

  assign unused_hi = ^din[DWIDTH+1:DWIDTH];
  assign dout      = din[DWIDTH-1:0];
`endif

endmodule

// File: rtl/branch_metric_calc.sv
// Branch metric stage: gamma_p = sys+apr+par, gamma_n = sys+apr-par over a
// 2-stage valid/ready pipeline with block framing. Option: BRANCH_METRIC_SAT_EN.
module branch_metric_calc
  import siso_pkg::*;
#(
  parameter int DWIDTH  = LLR_W_DEFAULT,
  parameter int BLK_LEN = BLK_LEN_DEFAULT,
  parameter int CNT_W   = cnt_width(BLK_LEN)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  branch_metric_calc_if.slave  bus
);

  localparam int              XW        = DWIDTH + 2;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BLK_LEN - 1);

  logic             st1_valid;
  logic [XW-1:0]    st1_sa;
  logic [XW-1:0]    st1_par;
  logic [CNT_W-1:0] st1_step;
  logic             st1_last;
  logic [CNT_W-1:0] step_cnt;

  logic             st2_ready;
  logic             accept;
  logic             advance;
  logic             at_end;
  logic             beat_last;
  logic             frame_mismatch;

  logic [XW-1:0]     gp_wide;
  logic [XW-1:0]     gn_wide;
  logic [DWIDTH-1:0] gp_narrow;
  logic [DWIDTH-1:0] gn_narrow;

  assign st2_ready      = !bus.m_valid || bus.m_ready;
  assign bus.s_ready    = aresetn && (!st1_valid || st2_ready);
  assign accept         = bus.s_valid && bus.s_ready;
  assign advance        = st1_valid && st2_ready;

  // A beat closes the block either on the counter or on an early s_last.
  assign at_end         = (step_cnt == LAST_STEP);
  assign beat_last      = at_end || bus.s_last;
  assign frame_mismatch = at_end ^ bus.s_last;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      st1_valid       <= 1'b0;
      st1_sa          <= '0;
      st1_par         <= '0;
      st1_step        <= '0;
      st1_last        <= 1'b0;
      step_cnt        <= '0;
      bus.o_frame_err <= 1'b0;
    end else begin
      bus.o_frame_err <= accept && frame_mismatch;
      if (accept) begin
        st1_valid <= 1'b1;
        st1_sa    <= {{2{bus.s_sys[DWIDTH-1]}}, bus.s_sys}
                   + {{2{bus.s_apr[DWIDTH-1]}}, bus.s_apr};
        st1_par   <= {{2{bus.s_par[DWIDTH-1]}}, bus.s_par};
        st1_step  <= step_cnt;
        st1_last  <= beat_last;
        step_cnt  <= beat_last ? '0 : step_cnt + 1'b1;
      end else if (advance) begin
        st1_valid <= 1'b0;
      end
    end
  end

  assign gp_wide = st1_sa + st1_par;
  assign gn_wide = st1_sa - st1_par;

  llr_narrow #(.DWIDTH(DWIDTH)) u_narrow_p (.din(gp_wide), .dout(gp_narrow));
  llr_narrow #(.DWIDTH(DWIDTH)) u_narrow_n (.din(gn_wide), .dout(gn_narrow));

  // Output registers only move when downstream can take a beat.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bus.m_valid   <= 1'b0;
      bus.m_gamma_p <= '0;
      bus.m_gamma_n <= '0;
      bus.m_last    <= 1'b0;
      bus.m_step    <= '0;
    end else if (st2_ready) begin
      bus.m_valid <= st1_valid;
      if (st1_valid) begin
        bus.m_gamma_p <= gp_narrow;
        bus.m_gamma_n <= gn_narrow;
        bus.m_last    <= st1_last;
        bus.m_step    <= st1_step;
      end
    end
  end

endmodule

// File: tb/tb_branch_metric_calc.sv
// Directed bench for branch_metric_calc: latency, narrowing, framing,
// random backpressure and mid-block reset.
module tb_branch_metric_calc;
  import siso_pkg::*;

  typedef struct packed {
    logic [15:0] gp;
    logic [15:0] gn;
    logic        last;
    logic [5:0]  step;
  } out_t;

  logic aclk;
  logic aresetn;
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;

  branch_metric_calc_if #(.DWIDTH(16), .CNT_W(6)) bus ();

  branch_metric_calc #(.DWIDTH(16), .BLK_LEN(64), .CNT_W(6)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
  always @(posedge aclk) begin
    #2;
    case (ready_mode)
      1:       bus.m_ready = ($urandom_range(0, 1) != 0);
      2:       bus.m_ready = 1'b0;
      default: bus.m_ready = 1'b1;
    endcase
  end

  int   n_acc = 0;
  int   inflight = 0;
  int   err_cnt = 0;
  int   err_acc = 0;
  int   stall_viol = 0;
  int   ready_viol = 0;
  logic prev_stall = 1'b0;
  logic exp_ready;
  out_t prev_out;
  out_t cur;
  out_t out_q[$];

  // Passive monitor sampling on the falling edge.
  always @(negedge aclk) begin
    cur = {bus.m_gamma_p, bus.m_gamma_n, bus.m_last, bus.m_step};
    if (!aresetn) begin
      inflight   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (bus.m_valid !== 1'b1 || cur !== prev_out)) stall_viol++;
      exp_ready = !(inflight == 2 && bus.m_ready === 1'b0);
      if (bus.s_ready !== exp_ready) ready_viol++;
      if (bus.o_frame_err === 1'b1) begin
        err_cnt++;
        err_acc = n_acc;
      end
      if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) begin
        n_acc++;
        inflight++;
      end
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        out_q.push_back(cur);
        inflight--;
      end
      prev_stall = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b0);
      prev_out   = cur;
    end
  end

  function automatic logic [15:0] exp_narrow(input int v);
    logic [31:0] t;
`ifdef BRANCH_METRIC_SAT_EN
    if (v > int'(LLR_SAT_MAX)) v = int'(LLR_SAT_MAX);
    else if (v < int'(LLR_SAT_MIN)) v = int'(LLR_SAT_MIN);
`endif
    t = v;
    return t[15:0];
  endfunction

  function automatic out_t exp_beat(input int sys, input int apr, input int par,
                                    input int step, input logic last);
    return {exp_narrow(sys + apr + par), exp_narrow(sys + apr - par), last, 6'(step)};
  endfunction

  // Holds one beat until accepted; call aligned just after a rising edge.
  task automatic send_beat(input int sys, input int apr, input int par, input logic last);
    logic ok;
    bus.s_valid = 1'b1;
    bus.s_sys   = 16'(sys);
    bus.s_apr   = 16'(apr);
    bus.s_par   = 16'(par);
    bus.s_last  = last;
    for (int t = 0; t < 500; t++) begin
      @(negedge aclk);
      ok = bus.s_ready;
      @(posedge aclk);
      #1;
      if (ok === 1'b1) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL accept_timeout: s_ready stayed low, required an accept within 500 cycles");
  endtask

  task automatic idle();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    idle();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn   = 1'b0;
    bus.s_sys = '0;
    bus.s_apr = '0;
    bus.s_par = '0;
    idle();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (bus.s_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_s_ready: got %b expected 0", bus.s_ready);
    end
    checks++;
    if ({bus.m_valid, bus.m_last, bus.o_frame_err, bus.m_step, bus.m_gamma_p, bus.m_gamma_n} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: valid=%b last=%b err=%b step=%0d gp=%0d gn=%0d expected all 0",
               bus.m_valid, bus.m_last, bus.o_frame_err, bus.m_step, bus.m_gamma_p, bus.m_gamma_n);
    end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_s_ready: got %b expected 1", bus.s_ready);
    end
  endtask

  task automatic test_latency();
    @(posedge aclk);
    #1;
    send_beat(100, 20, 30, 1'b0);
    idle();
    @(negedge aclk);
    checks++;
    if (bus.m_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_early: m_valid=%b one cycle after accept, expected 0", bus.m_valid);
    end
    @(negedge aclk);
    checks++;
    if (bus.m_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_valid: m_valid=%b two cycles after accept, expected 1", bus.m_valid);
    end
    checks++;
    if ({bus.m_gamma_p, bus.m_gamma_n} !== {16'd150, 16'd90}) begin
      errors++;
      $display("[TB] FAIL basic_gamma: gp=%0d gn=%0d expected gp=150 gn=90",
               $signed(bus.m_gamma_p), $signed(bus.m_gamma_n));
    end
    checks++;
    if ({bus.m_last, bus.m_step} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL basic_step: last=%b step=%0d expected last=0 step=0", bus.m_last, bus.m_step);
    end
  endtask

  task automatic test_narrowing();
    logic [15:0] exp_gp_hi, exp_gn_hi, exp_lo;
`ifdef BRANCH_METRIC_SAT_EN
    exp_gp_hi = LLR_SAT_MAX;
    exp_gn_hi = LLR_SAT_MAX;
    exp_lo    = LLR_SAT_MIN;
`else
    exp_gp_hi = 16'd32765;
    exp_gn_hi = 16'd32767;
    exp_lo    = 16'd0;
`endif
    @(posedge aclk);
    #1;
    send_beat(32767, 32767, 32767, 1'b0);
    idle();
    repeat (2) @(negedge aclk);
    checks++;
    if ({bus.m_gamma_p, bus.m_gamma_n} !== {exp_gp_hi, exp_gn_hi}) begin
      errors++;
      $display("[TB] FAIL narrow_max: gp=%0d gn=%0d expected gp=%0d gn=%0d",
               $signed(bus.m_gamma_p), $signed(bus.m_gamma_n), $signed(exp_gp_hi), $signed(exp_gn_hi));
    end
    @(posedge aclk);
    #1;
    send_beat(-32768, -32768, 0, 1'b0);
    idle();
    repeat (2) @(negedge aclk);
    checks++;
    if ({bus.m_gamma_p, bus.m_gamma_n} !== {exp_lo, exp_lo}) begin
      errors++;
      $display("[TB] FAIL narrow_min: gp=%0d gn=%0d expected both %0d",
               $signed(bus.m_gamma_p), $signed(bus.m_gamma_n), $signed(exp_lo));
    end
  endtask

  task automatic test_block_framing();
    int   base_out, base_acc, base_err;
    out_t exp;
    do_reset();
    base_out = out_q.size();
    base_acc = n_acc;
    base_err = err_cnt;
    for (int i = 0; i < 64; i++) send_beat(i, 2 * i, 1000 - 5 * i, (i == 63));
    idle();
    repeat (4) @(negedge aclk);
    checks++;
    if (err_cnt - base_err !== 0) begin
      errors++;
      $display("[TB] FAIL frame_clean_block: o_frame_err pulses=%0d expected 0", err_cnt - base_err);
    end
    @(posedge aclk);
    #1;
    for (int i = 0; i < 12; i++) send_beat(64 + i, 7, -3, (i == 10));
    idle();
    repeat (5) @(negedge aclk);
    checks++;
    if (out_q.size() - base_out !== 76) begin
      errors++;
      $display("[TB] FAIL frame_count: got %0d beats expected 76", out_q.size() - base_out);
    end else begin
      for (int i = 0; i < 64; i++) begin
        exp = exp_beat(i, 2 * i, 1000 - 5 * i, i, (i == 63));
        checks++;
        if (out_q[base_out + i] !== exp) begin
          errors++;
          $display("[TB] FAIL frame_beat%0d: got %h expected %h", i, out_q[base_out + i], exp);
        end
      end
      checks++;
      if ({out_q[base_out + 73].last, out_q[base_out + 74].last, out_q[base_out + 74].step}
          !== {1'b0, 1'b1, 6'd10}) begin
        errors++;
        $display("[TB] FAIL early_last: beat9 last=%b beat10 last=%b step=%0d expected 0,1,10",
                 out_q[base_out + 73].last, out_q[base_out + 74].last, out_q[base_out + 74].step);
      end
      checks++;
      if (out_q[base_out + 75].step !== 6'd0) begin
        errors++;
        $display("[TB] FAIL resync_step: got %0d expected 0", out_q[base_out + 75].step);
      end
    end
    checks++;
    if ({err_cnt - base_err, err_acc - base_acc} !== {32'd1, 32'd75}) begin
      errors++;
      $display("[TB] FAIL frame_err_pulse: pulses=%0d at accept#%0d expected 1 at accept#75",
               err_cnt - base_err, err_acc - base_acc);
    end
  endtask

  task automatic test_back_to_back_random();
    int   base_out, base_err, base_stall, base_ready, k;
    out_t exp;
    do_reset();
    ready_mode = 1;
    base_out   = out_q.size();
    base_err   = err_cnt;
    base_stall = stall_viol;
    base_ready = ready_viol;
    for (int i = 0; i < 192; i++) send_beat(i, i + 1, 3 * i - 100, ((i % 64) == 63));
    idle();
    k = 0;
    while ((out_q.size() - base_out < 192) && (k < 3000)) begin
      @(negedge aclk);
      k++;
    end
    ready_mode = 0;
    checks++;
    if (out_q.size() - base_out !== 192) begin
      errors++;
      $display("[TB] FAIL random_count: got %0d beats expected 192", out_q.size() - base_out);
    end else begin
      for (int i = 0; i < 192; i++) begin
        exp = exp_beat(i, i + 1, 3 * i - 100, i % 64, ((i % 64) == 63));
        checks++;
        if (out_q[base_out + i] !== exp) begin
          errors++;
          $display("[TB] FAIL random_beat%0d: got %h expected %h", i, out_q[base_out + i], exp);
        end
      end
    end
    checks++;
    if (stall_viol - base_stall !== 0) begin
      errors++;
      $display("[TB] FAIL stall_stable: %0d output changes while stalled, expected 0", stall_viol - base_stall);
    end
    checks++;
    if (ready_viol - base_ready !== 0) begin
      errors++;
      $display("[TB] FAIL s_ready_rule: %0d cycles with wrong s_ready, expected 0", ready_viol - base_ready);
    end
    checks++;
    if (err_cnt - base_err !== 0) begin
      errors++;
      $display("[TB] FAIL random_frame_err: got %0d pulses expected 0", err_cnt - base_err);
    end
  endtask

  task automatic test_reset_midblock();
    do_reset();
    ready_mode = 2;
    send_beat(40, 2, 9, 1'b0);
    send_beat(41, 2, 9, 1'b0);
    idle();
    @(negedge aclk);
    checks++;
    if ({bus.s_ready, bus.m_valid} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL full_pipe: s_ready=%b m_valid=%b expected s_ready=0 m_valid=1",
               bus.s_ready, bus.m_valid);
    end
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if ({bus.m_valid, bus.m_last, bus.o_frame_err, bus.m_step, bus.m_gamma_p, bus.m_gamma_n} !== '0) begin
      errors++;
      $display("[TB] FAIL midblock_reset: valid=%b last=%b err=%b step=%0d gp=%0d gn=%0d expected all 0",
               bus.m_valid, bus.m_last, bus.o_frame_err, bus.m_step, bus.m_gamma_p, bus.m_gamma_n);
    end
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midblock_s_ready: got %b expected 1", bus.s_ready);
    end
    ready_mode = 0;
    @(posedge aclk);
    #1;
    send_beat(5, 5, 5, 1'b0);
    idle();
    repeat (2) @(negedge aclk);
    checks++;
    if ({bus.m_valid, bus.m_step, bus.m_gamma_p, bus.m_gamma_n} !== {1'b1, 6'd0, 16'd15, 16'd5}) begin
      errors++;
      $display("[TB] FAIL restart_step: valid=%b step=%0d gp=%0d gn=%0d expected 1,0,15,5",
               bus.m_valid, bus.m_step, bus.m_gamma_p, bus.m_gamma_n);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_narrowing();
    test_block_framing();
    test_back_to_back_random();
    test_reset_midblock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
